// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port, two
// combinational read ports, optional hardwired-zero register 0, optional
// same-cycle write-to-read bypass, and a per-register pending scoreboard
// used by issue logic to detect read-after-write hazards.
module regfile_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_reserve,
    input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Architectural state and its next-state values.
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [DEPTH-1:0]      pending_d;
    logic [ADDR_WIDTH:0]   pending_count_q;
    logic [ADDR_WIDTH:0]   pending_count_d;

    // Qualified write/reserve strobes: register 0 is immune when hardwired.
    logic write_ok;
    logic reserve_ok;

    // Read ports handled uniformly as a two-entry array.
    logic [ADDR_WIDTH-1:0] rd_idx  [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_busy [2];

    assign write_ok   = ctrl_writeEnable && !(ZERO_REG && (ctrl_writeReg == '0));
    assign reserve_ok = ctrl_reserve     && !(ZERO_REG && (ctrl_reserveReg == '0));

    assign rd_idx[0] = ctrl_readRegA;
    assign rd_idx[1] = ctrl_readRegB;

    // Next-state for storage and scoreboard; reserve is applied after the write
    // so a same-index reserve leaves the register pending (new producer wins).
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        regs_d    = regs_q;
        pending_d = pending_q;
        if (write_ok) begin
            regs_d[ctrl_writeReg]    = data_writeReg;
            pending_d[ctrl_writeReg] = 1'b0;
        end
        if (reserve_ok) begin
            pending_d[ctrl_reserveReg] = 1'b1;
        end
    end

    // Population count of the next-state pending vector, registered below so
    // pending_count is exact the cycle after each edge.
    always_comb begin
        pending_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_count_d = pending_count_d + {{ADDR_WIDTH{1'b0}}, pending_d[i]};
        end
    end

    // State registers with synchronous reset that overrides writes and reserves.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (ctrl_reset) begin
            // NOTE: the storage array is reset explicitly because reset must
            // leave every register reading zero; this costs a reset net on
            // every bit and rules out mapping the array onto a RAM macro.
            regs_q          <= '{default: '0};
            pending_q       <= '0;
            pending_count_q <= '0;
        end else begin
            regs_q          <= regs_d;
            pending_q       <= pending_d;
            pending_count_q <= pending_count_d;
        end
    end

    // Combinational read ports: stored value, optional bypass of the in-flight
    // write (which also clears busy), and the hardwired-zero override last.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_idx[p]];
            rd_busy[p] = pending_q[rd_idx[p]];
            if (BYPASS && ctrl_writeEnable && !ctrl_reset
                && (ctrl_writeReg == rd_idx[p])) begin
                rd_data[p] = data_writeReg;
                rd_busy[p] = 1'b0;
            end
            if (ZERO_REG && (rd_idx[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign data_readRegA = rd_data[0];
    assign data_readRegB = rd_data[1];
    assign busy_readRegA = rd_busy[0];
    assign busy_readRegB = rd_busy[1];
    assign pending_count = pending_count_q;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor of the 32x32 register file: one write port, two combinational read ports, configurable width and depth, and a register-0-hardwired-zero option. Adds two behaviours the fixed-size file lacks: same-cycle write-to-read bypass, and a per-register pending scoreboard that issue logic uses to detect read-after-write hazards. Sits between decode (read/reserve) and writeback (write) in the processor datapath.

## Interface
- DATA_WIDTH, 32, bits per register
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH
- ZERO_REG, 1, 1: register 0 always reads 0, never written, never pending; 0: register 0 is ordinary
- BYPASS, 1, 1: a write in the current cycle is forwarded to matching read ports; 0: reads show stored contents only

Ports:
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  reset; synchronous, active-high
- ctrl_writeEnable  in  1  commit data_writeReg into ctrl_writeReg at the edge
- ctrl_writeReg  in  ADDR_WIDTH  write index
- data_writeReg  in  DATA_WIDTH  write data
- ctrl_reserve  in  1  mark ctrl_reserveReg pending at the edge
- ctrl_reserveReg  in  ADDR_WIDTH  reserve index
- ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read indices
- data_readRegA, data_readRegB  out  DATA_WIDTH  read data, combinational
- busy_readRegA, busy_readRegB  out  1  selected register has an outstanding write, combinational
- pending_count  out  ADDR_WIDTH+1  number of pending registers, registered

## Operation
- Storage: DEPTH x DATA_WIDTH registers plus DEPTH pending bits, all in clock domain.
- Write: at rising edge, if ctrl_writeEnable=1 and ctrl_reset=0, reg[ctrl_writeReg] <= data_writeReg and pending[ctrl_writeReg] <= 0. Ignored for index 0 when ZERO_REG=1.
- Reserve: at rising edge, if ctrl_reserve=1 and ctrl_reset=0, pending[ctrl_reserveReg] <= 1. Ignored for index 0 when ZERO_REG=1.
- Reserve and write to the same index in the same cycle: data is written, pending ends 1 (the new producer wins).
- Read X in {A,B}: data_readRegX = reg[ctrl_readRegX]. If BYPASS=1, ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeReg==ctrl_readRegX and the index is not a suppressed zero register, then data_readRegX = data_writeReg instead.
- Index 0 with ZERO_REG=1: data_readRegX = 0 and busy_readRegX = 0 unconditionally.
- busy_readRegX = pending[ctrl_readRegX]. With BYPASS=1, it is forced to 0 when the same-cycle write hits that index, so the consumer can take the bypassed value.
- pending_count: population count of the pending bits, registered. It equals the count of the next-state pending vector, so it is exact one cycle after each edge.
- Both read ports may address the same register; each resolves independently.

## Timing
- Reset (ctrl_reset=1 at an edge): all registers <= 0, all pending <= 0, pending_count <= 0. Writes and reserves in that cycle are discarded. Bypass is suppressed while ctrl_reset=1.
- Reset takes priority over every other input. Reset arriving while registers are pending clears them, and nothing is carried over.
- Write latency: data is visible on the stored-read path the cycle after the edge. With BYPASS=1 it is visible in the same cycle as the write request.
- Reserve latency: busy rises the cycle after the reserving edge. There is no same-cycle reserve forwarding.
- Read ports: purely combinational from indices and state, with no clock latency.
- Index wrap: none. All indices are ADDR_WIDTH wide and cover exactly DEPTH entries.
- pending_count range: 0..DEPTH (DEPTH-1 when ZERO_REG=1). It cannot overflow.

## Test plan
- Reset then read all indices on A and B -> every data_readRegX=0, busy=0, pending_count=0.
- Write 0xDEADBEEF to r5, then read A=5 the same cycle (BYPASS=1) -> data_readRegA=0xDEADBEEF that cycle; with BYPASS=0, reads 0 that cycle and 0xDEADBEEF the next.
- Write 0x12345678 to r0 with ZERO_REG=1, and reserve r0 -> r0 reads 0, busy_readRegA=0, pending_count unchanged; with ZERO_REG=0, r0 reads 0x12345678 next cycle.
- Reserve r3, r7, r9 on consecutive cycles -> pending_count 1,2,3. Write r7 with B=7 -> busy_readRegB=0 same cycle (BYPASS=1), pending_count=2 next cycle.
- Same-cycle reserve r4 and write r4=0xA5A5A5A5 -> next cycle r4 reads 0xA5A5A5A5, busy=1, pending_count +1.
- With r2 pending and holding 0x55, assert ctrl_reset together with a write of 0x99 to r2 -> next cycle r2=0, busy=0, pending_count=0.
